// File: rtl/soc_pll_seq_pkg.sv
// Shared types for the SoC PLL power-up/recovery sequencer.
package soc_clk_pkg;

    // Sequencer FSM states; encoding is visible on o_state
    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4,
        FAIL      = 3'd5
    } pll_seq_state_e;

    // Domain reset bit positions, released LSB first
    localparam int unsigned DOM_DDR  = 0;
    localparam int unsigned DOM_BUS  = 1;
    localparam int unsigned DOM_CORE = 2;
    localparam int unsigned DOM_RTC  = 3;

    // Larger of two unsigned values, used to size the shared cycle counter
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/soc_pll_seq_if.sv
// Control/status bundle between the PLL sequencer and its surroundings.
interface soc_pll_seq_if #(
    parameter int unsigned N_DOM = 4
);
    import soc_clk_pkg::*;

    logic               i_pll_lock;
    logic               i_sw_rst;
    logic               o_pll_rst;
    logic [N_DOM-1:0]   o_dom_rst_n;
    logic               o_ready;
    logic               o_fail;
    pll_seq_state_e     o_state;
    logic [2:0]         o_retry_cnt;
    logic [7:0]         o_lockloss_cnt;

    // Sequencer side
    modport master (
        input  i_pll_lock, i_sw_rst,
        output o_pll_rst, o_dom_rst_n, o_ready, o_fail, o_state, o_retry_cnt, o_lockloss_cnt
    );

    // Consumer / controller side
    modport slave (
        output i_pll_lock, i_sw_rst,
        input  o_pll_rst, o_dom_rst_n, o_ready, o_fail, o_state, o_retry_cnt, o_lockloss_cnt
    );

endinterface

// File: rtl/soc_pll_seq_sync_2ff.sv
// Generic two-flop synchronizer, clears to 0 on reset.
module soc_sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/soc_pll_seq.sv
// SoC PLL power-up/recovery sequencer: PLL reset, lock wait with timeout and
// retry, lock qualification, staggered domain reset release, lock-loss restart.
// Optional feature macro: SOC_PLL_SEQ_LOCKLOSS_CNT_EN enables the saturating
// lock-loss event counter on o_lockloss_cnt (otherwise tied to zero).
module soc_pll_seq
    import soc_clk_pkg::*;
#(
    parameter int unsigned RST_CYCLES     = 64,
    parameter int unsigned LOCK_TIMEOUT   = 50000,
    parameter int unsigned STABLE_CYCLES  = 1024,
    parameter int unsigned STAGGER_CYCLES = 16,
    parameter int unsigned MAX_RETRY      = 4,
    parameter int unsigned N_DOM          = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    soc_pll_seq_if.master bus
);

    localparam int unsigned CNT_W = $clog2(max_u(max_u(RST_CYCLES, LOCK_TIMEOUT),
                                                 max_u(STABLE_CYCLES, STAGGER_CYCLES))) + 1;
    localparam int unsigned IDX_W = (N_DOM > 1) ? $clog2(N_DOM) : 1;

    pll_seq_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [2:0]       retry_q, retry_d;
    logic [N_DOM-1:0] dom_q, dom_d;
    logic             pll_rst_q, pll_rst_d;
    logic             ready_q, ready_d;
    logic             fail_q, fail_d;
    logic             lock_s;

    soc_sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .d     (bus.i_pll_lock),
        .q     (lock_s)
    );

    // State, timing and registered-output flops
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= PLL_RST;
            cnt_q     <= '0;
            idx_q     <= '0;
            retry_q   <= '0;
            dom_q     <= '0;
            pll_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            retry_q   <= retry_d;
            dom_q     <= dom_d;
            pll_rst_q <= pll_rst_d;
            ready_q   <= ready_d;
            fail_q    <= fail_d;
        end
    end

    // Next-state, counter and output decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        retry_d = retry_q;
        dom_d   = dom_q;

        case (state_q)
            PLL_RST: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                    state_d = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (lock_s) begin
                    state_d = STABLE;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    retry_d = (retry_q == 3'd7) ? retry_q : retry_q + 3'd1;
                    state_d = ((32'(retry_q) + 32'd1) >= MAX_RETRY) ? FAIL : PLL_RST;
                end
            end
            STABLE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                    state_d = RELEASE;
                    retry_d = '0;
                    idx_d   = '0;
                end
            end
            RELEASE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!lock_s) begin
                    state_d = PLL_RST;
                    dom_d   = '0;
                end else if (cnt_q == CNT_W'(STAGGER_CYCLES - 1)) begin
                    dom_d[idx_q] = 1'b1;
                    cnt_d        = '0;
                    if (idx_q == IDX_W'(N_DOM - 1)) begin
                        state_d = RUN;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = PLL_RST;
                    dom_d   = '0;
                end
            end
            FAIL: begin
                dom_d = '0;
            end
            default: begin
                state_d = PLL_RST;
                dom_d   = '0;
            end
        endcase

        // Every state change restarts the shared timer
        if (state_d != state_q) begin
            cnt_d = '0;
        end

        // Software restart overrides everything, including a coincident lock loss
        if (bus.i_sw_rst) begin
            state_d = PLL_RST;
            cnt_d   = '0;
            idx_d   = '0;
            retry_d = '0;
            dom_d   = '0;
        end

        pll_rst_d = (state_d == PLL_RST) || (state_d == FAIL);
        ready_d   = (state_d == RUN);
        fail_d    = (state_d == FAIL);
    end

`ifdef SOC_PLL_SEQ_LOCKLOSS_CNT_EN
    logic [7:0] lockloss_q;
    logic       lockloss_c;

    assign lockloss_c = !bus.i_sw_rst && !lock_s &&
                        ((state_q == RELEASE) || (state_q == RUN));

    // Saturating lock-loss event counter, cleared only by hardware reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lockloss_q <= '0;
        end else if (lockloss_c && (lockloss_q != 8'hFF)) begin
            lockloss_q <= lockloss_q + 8'd1;
        end
    end

    assign bus.o_lockloss_cnt = lockloss_q;
`else
    assign bus.o_lockloss_cnt = 8'd0;
`endif

    assign bus.o_pll_rst   = pll_rst_q;
    assign bus.o_dom_rst_n = dom_q;
    assign bus.o_ready     = ready_q;
    assign bus.o_fail      = fail_q;
    assign bus.o_state     = state_q;
    assign bus.o_retry_cnt = retry_q;

endmodule

// File: tb/tb_soc_pll_seq.sv
// Directed bench for soc_pll_seq with short timing parameters; edges are
// counted from i_rst_n release.
module tb_soc_pll_seq;
    import soc_clk_pkg::*;

`ifdef SOC_PLL_SEQ_LOCKLOSS_CNT_EN
    localparam int unsigned LL_EXP = 1;
`else
    localparam int unsigned LL_EXP = 0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   cur;
    logic [3:0] dom_acc;

    soc_pll_seq_if #(.N_DOM(4)) bus ();

    soc_pll_seq #(
        .RST_CYCLES     (4),
        .LOCK_TIMEOUT   (20),
        .STABLE_CYCLES  (8),
        .STAGGER_CYCLES (2),
        .MAX_RETRY      (2),
        .N_DOM          (4)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Single comparison point: count and report mismatches
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, act, exp, cur);
        end
    endtask

    // Advance to a given edge count, sampling 1 time unit after each edge
    task automatic goto(input int e);
        while (cur < e) begin
            @(posedge clk);
            #1;
            cur++;
            dom_acc |= bus.o_dom_rst_n;
        end
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_state"},    32'(bus.o_state),        32'(PLL_RST));
        check({pfx, "_pll_rst"},  32'(bus.o_pll_rst),      32'd1);
        check({pfx, "_dom"},      32'(bus.o_dom_rst_n),    32'h0);
        check({pfx, "_ready"},    32'(bus.o_ready),        32'd0);
        check({pfx, "_fail"},     32'(bus.o_fail),         32'd0);
        check({pfx, "_retry"},    32'(bus.o_retry_cnt),    32'd0);
        check({pfx, "_lockloss"}, 32'(bus.o_lockloss_cnt), 32'd0);
    endtask

    // Assert reset between edges, check async values, release mid-high-phase
    task automatic do_reset(input string pfx);
        bus.i_sw_rst = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_vals(pfx);
        repeat (2) @(posedge clk);
        #5;
        rst_n   = 1'b1;
        cur     = 0;
        dom_acc = '0;
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        cur          = 0;
        dom_acc      = '0;
        rst_n        = 1'b1;
        bus.i_sw_rst = 1'b0;

        // Lock high from power-up, then lock loss in RUN
        bus.i_pll_lock = 1'b1;
        do_reset("rst1");
        goto(3);  check("s1_pll_rst_e3", 32'(bus.o_pll_rst), 32'd1);
        goto(4);  check("s1_pll_rst_e4", 32'(bus.o_pll_rst), 32'd0);
                  check("s1_state_e4",   32'(bus.o_state),   32'(WAIT_LOCK));
        goto(5);  check("s1_state_e5",   32'(bus.o_state),   32'(STABLE));
        goto(12); check("s1_state_e12",  32'(bus.o_state),   32'(STABLE));
        goto(13); check("s1_state_e13",  32'(bus.o_state),   32'(RELEASE));
        goto(14); check("s1_dom_e14",    32'(bus.o_dom_rst_n), 32'h0);
        goto(15); check("s1_dom_e15",    32'(bus.o_dom_rst_n), 32'h1);
        goto(16); check("s1_dom_e16",    32'(bus.o_dom_rst_n), 32'h1);
        goto(17); check("s1_dom_e17",    32'(bus.o_dom_rst_n), 32'h3);
        goto(19); check("s1_dom_e19",    32'(bus.o_dom_rst_n), 32'h7);
        goto(20); check("s1_ready_e20",  32'(bus.o_ready),     32'd0);
        goto(21); check("s1_dom_e21",    32'(bus.o_dom_rst_n), 32'hF);
                  check("s1_ready_e21",  32'(bus.o_ready),     32'd1);
                  check("s1_state_e21",  32'(bus.o_state),     32'(RUN));
        goto(25); bus.i_pll_lock = 1'b0;
        goto(27); check("s3_ready_e27",  32'(bus.o_ready),     32'd1);
                  check("s3_ll_e27",     32'(bus.o_lockloss_cnt), 32'd0);
        goto(28); check("s3_ready_e28",  32'(bus.o_ready),     32'd0);
                  check("s3_dom_e28",    32'(bus.o_dom_rst_n), 32'h0);
                  check("s3_pll_rst_e28", 32'(bus.o_pll_rst),  32'd1);
                  check("s3_state_e28",  32'(bus.o_state),     32'(PLL_RST));
                  check("s3_retry_e28",  32'(bus.o_retry_cnt), 32'd0);
                  check("s3_ll_e28",     32'(bus.o_lockloss_cnt), LL_EXP);

        // Lock tied low: one retry then FAIL; then software restart
        bus.i_pll_lock = 1'b0;
        do_reset("rst2");
        goto(23); check("s2_state_e23",  32'(bus.o_state),     32'(WAIT_LOCK));
                  check("s2_retry_e23",  32'(bus.o_retry_cnt), 32'd0);
        goto(24); check("s2_state_e24",  32'(bus.o_state),     32'(PLL_RST));
                  check("s2_retry_e24",  32'(bus.o_retry_cnt), 32'd1);
                  check("s2_pll_rst_e24", 32'(bus.o_pll_rst),  32'd1);
        goto(28); check("s2_state_e28",  32'(bus.o_state),     32'(WAIT_LOCK));
        goto(47); check("s2_fail_e47",   32'(bus.o_fail),      32'd0);
        goto(48); check("s2_fail_e48",   32'(bus.o_fail),      32'd1);
                  check("s2_state_e48",  32'(bus.o_state),     32'(FAIL));
                  check("s2_retry_e48",  32'(bus.o_retry_cnt), 32'd2);
                  check("s2_pll_rst_e48", 32'(bus.o_pll_rst),  32'd1);
                  check("s2_dom_never",  32'(dom_acc),         32'h0);
                  bus.i_pll_lock = 1'b1;
        goto(51); check("s5_state_e51",  32'(bus.o_state),     32'(FAIL));
                  bus.i_sw_rst = 1'b1;
        goto(52); check("s5_state_e52",  32'(bus.o_state),     32'(PLL_RST));
                  check("s5_fail_e52",   32'(bus.o_fail),      32'd0);
                  check("s5_retry_e52",  32'(bus.o_retry_cnt), 32'd0);
                  check("s5_pll_rst_e52", 32'(bus.o_pll_rst),  32'd1);
                  bus.i_sw_rst = 1'b0;
        goto(55); check("s5_pll_rst_e55", 32'(bus.o_pll_rst),  32'd1);
        goto(56); check("s5_pll_rst_e56", 32'(bus.o_pll_rst),  32'd0);
        goto(57); check("s5_state_e57",  32'(bus.o_state),     32'(STABLE));
        goto(65); check("s5_state_e65",  32'(bus.o_state),     32'(RELEASE));
        goto(67); check("s5_dom_e67",    32'(bus.o_dom_rst_n), 32'h1);
        goto(73); check("s5_dom_e73",    32'(bus.o_dom_rst_n), 32'hF);
                  check("s5_ready_e73",  32'(bus.o_ready),     32'd1);

        // One-cycle lock glitch during STABLE restarts the qualification window
        bus.i_pll_lock = 1'b1;
        do_reset("rst4");
        goto(7);  bus.i_pll_lock = 1'b0;
        goto(8);  bus.i_pll_lock = 1'b1;
        goto(9);  check("s4_state_e9",   32'(bus.o_state),     32'(STABLE));
        goto(10); check("s4_state_e10",  32'(bus.o_state),     32'(WAIT_LOCK));
                  check("s4_retry_e10",  32'(bus.o_retry_cnt), 32'd0);
        goto(11); check("s4_state_e11",  32'(bus.o_state),     32'(STABLE));
        goto(18); check("s4_state_e18",  32'(bus.o_state),     32'(STABLE));
        goto(19); check("s4_state_e19",  32'(bus.o_state),     32'(RELEASE));
        goto(21); check("s4_dom_e21",    32'(bus.o_dom_rst_n), 32'h1);
        goto(27); check("s4_ready_e27",  32'(bus.o_ready),     32'd1);
                  check("s4_dom_e27",    32'(bus.o_dom_rst_n), 32'hF);
                  check("s4_retry_e27",  32'(bus.o_retry_cnt), 32'd0);

        // Hardware reset asserted mid-RELEASE, away from any clock edge
        do_reset("rst6");
        goto(18); check("s6_state_e18",  32'(bus.o_state),     32'(RELEASE));
                  check("s6_dom_e18",    32'(bus.o_dom_rst_n), 32'h3);
        #5;
        rst_n = 1'b0;
        #1;
        check_reset_vals("s6_async");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
